// File: rtl/nibble_alu_seq.sv
// Multi-cycle add/subtract unit: a WIDTH-bit operation runs through one shared
// 4-bit slice, LSB nibble first, one nibble per clock, with full-word flags.
module nibble_alu_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_x,
    input  logic [4*NIBBLES-1:0]   in_y,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_z,
    output logic                   out_v,
    output logic                   out_c,
    output logic                   out_n,
    output logic                   out_zf,
    output logic                   out_lt,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int CW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; out_valid holds with stable data until out_ready is seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_nx;
    logic [WIDTH-1:0]   x_r, y_r, res_r;
    logic [CW-1:0]      cnt_r;
    logic               carry_r, zacc_r;
    logic               v_r, c_r, n_r, zf_r, lt_r;

    logic [3:0]         x4, y4, lo, s;
    logic               c3, cout, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nx;
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // One 4-bit slice; carry into its top bit is kept separate for overflow.
    always_comb begin
        x4   = x_r[{cnt_r, 2'b00} +: 4];
        y4   = y_r[{cnt_r, 2'b00} +: 4];
        lo   = {1'b0, x4[2:0]} + {1'b0, y4[2:0]} + {3'b000, carry_r};
        c3   = lo[3];
        s    = {x4[3] ^ y4[3] ^ c3, lo[2:0]};
        cout = (x4[3] & y4[3]) | (c3 & (x4[3] ^ y4[3]));
        last = (cnt_r == CW'(NIBBLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            y_r     <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            zacc_r  <= 1'b0;
            v_r     <= 1'b0;
            c_r     <= 1'b0;
            n_r     <= 1'b0;
            zf_r    <= 1'b0;
            lt_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: if (in_valid) begin
                    x_r     <= in_x;
                    y_r     <= in_sub ? ~in_y : in_y;
                    carry_r <= in_sub;
                    cnt_r   <= '0;
                    zacc_r  <= 1'b0;
                end
                RUN: begin
                    res_r[{cnt_r, 2'b00} +: 4] <= s;
                    carry_r <= cout;
                    zacc_r  <= zacc_r | (|s);
                    if (last) begin
                        cnt_r <= '0;
                        c_r   <= cout;
                        v_r   <= c3 ^ cout;
                        n_r   <= s[3];
                        zf_r  <= ~(zacc_r | (|s));
                        lt_r  <= s[3] ^ c3 ^ cout;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign state_dbg = state_r;
    assign out_z     = res_r;
    assign out_v     = v_r;
    assign out_c     = c_r;
    assign out_n     = n_r;
    assign out_zf    = zf_r;
    assign out_lt    = lt_r;

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Bench for nibble_alu_seq (NIBBLES=4): table of directed add/sub vectors plus
// hand-written backpressure and mid-operation reset sequences.
module tb_nibble_alu_seq;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [15:0] in_x, in_y, out_z;
    logic        out_valid, out_ready;
    logic        out_v, out_c, out_n, out_zf, out_lt, busy;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    nibble_alu_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_v(out_v), .out_c(out_c), .out_n(out_n),
        .out_zf(out_zf), .out_lt(out_lt), .busy(busy), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        sub;
        logic [15:0] z;
        logic        v, c, n, zf, lt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE, wait for the result, check it, then accept it.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_x = v.x; in_y = v.y; in_sub = v.sub;
        @(negedge clk);
        in_valid = 1'b0; in_x = $urandom_range(0, 16'hFFFF); in_y = $urandom_range(0, 16'hFFFF);
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("out_z", 32'(out_z), 32'(v.z));
        check("out_v", 32'(out_v), 32'(v.v));
        check("out_c", 32'(out_c), 32'(v.c));
        check("out_n", 32'(out_n), 32'(v.n));
        check("out_zf", 32'(out_zf), 32'(v.zf));
        if (v.sub) check("out_lt", 32'(out_lt), 32'(v.lt));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_accept", 32'(out_valid), 32'd0);
        check("in_ready_after_accept", 32'(in_ready), 32'd1);
    endtask

    initial begin
        //           x        y        sub   z        v     c     n     zf    lt
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h0003, 16'h0007, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_z", 32'(out_z), 32'd0);
        check("rst_flags", 32'({out_v, out_c, out_n, out_zf, out_lt}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Backpressure in DONE: result held, new requests ignored.
        @(negedge clk);
        in_valid = 1'b1; in_x = 16'h1234; in_y = 16'h0FFF; in_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_x = 16'hAAAA; in_y = 16'h5555; in_sub = 1'b1;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_z", 32'(out_z), 32'h2233);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_state", 32'(state_dbg), 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_stays_idle", 32'(busy), 32'd0);

        // Reset during RUN nibble 2 drops the operation immediately.
        in_valid = 1'b1; in_x = 16'hFFFF; in_y = 16'hFFFF; in_sub = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_z", 32'(out_z), 32'd0);
        check("mid_rst_flags", 32'({out_v, out_c, out_n, out_zf, out_lt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
